// File: rtl/exp_accumulate_block.sv
// exp_accumulate_block
// Softmax exponent stage. Takes the non-positive differences (x - max) from
// the max-subtract stage, computes exp(x) in fixed point with a 3-cycle
// pipeline, streams each exp value out with its index in the frame, and
// accumulates the frame sum (softmax denominator) for the divide stage.
//
// Ports:
//   clock_i      rising-edge clock
//   reset_i      synchronous active-high reset
//   valid_i      sub_data_i valid this cycle (no backpressure)
//   sub_data_i   signed x - max, FRAC_BITS fractional bits
//   exp_o        unsigned Q1.15 exp(x), 1.0 = 32768 (held while valid_o = 0)
//   valid_o      exp_o / index_o valid, 3 cycles after valid_i
//   index_o      element index of exp_o within the frame, 0..N-1
//   sum_o        unsigned Q.15 sum of the frame's exp values (held)
//   sum_valid_o  one-cycle pulse alongside the last element of a frame
module exp_accumulate_block #(
  parameter int DATA_SIZE      = 16,
  parameter int NUMBER_OF_DATA = 10,
  parameter int FRAC_BITS      = 8,
  parameter int SUM_WIDTH      = 16 + $clog2(NUMBER_OF_DATA)
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic                              valid_i,
  input  logic signed [DATA_SIZE:0]         sub_data_i,
  output logic [15:0]                       exp_o,
  output logic                              valid_o,
  output logic [$clog2(NUMBER_OF_DATA)-1:0] index_o,
  output logic [SUM_WIDTH-1:0]              sum_o,
  output logic                              sum_valid_o
);

  localparam int XW    = DATA_SIZE + 1;
  localparam int PW    = XW + 17;         // signed x * unsigned 16-bit constant
  localparam int SHIFT = FRAC_BITS + 15;  // fraction bits of the product
  localparam int KW    = PW - SHIFT;      // integer-part width of the product
  localparam int IDX_W = $clog2(NUMBER_OF_DATA);

  // log2(e) in Q1.15, carried as a positive 17-bit signed operand
  localparam logic signed [16:0]    LOG2E_Q15 = 17'sd47274;
  localparam logic signed [KW-1:0]  S_SAT     = KW'(31);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUMBER_OF_DATA - 1);

  // 2^(j/64) in Q1.15, j = 0..63 (32768..64830)
  logic [15:0] lut_rom [64];
  for (genvar gi = 0; gi < 64; gi++) begin : g_lut
    localparam real         ENTRY_R = 32768.0 * (2.0 ** (real'(gi) / 64.0));
    localparam logic [15:0] ENTRY   = 16'($rtoi(ENTRY_R + 0.5));
    assign lut_rom[gi] = ENTRY;
  end

  // ---------------- Stage 1: clamp and scale to base 2 ----------------
  logic signed [XW-1:0]   x_clamped;
  logic signed [PW-1:0]   p_full;
  logic signed [KW+5:0]   p_d;          // integer part + top 6 fraction bits
  logic                   unused_p_low;

  assign x_clamped    = sub_data_i[XW-1] ? sub_data_i : '0;
  assign p_full       = x_clamped * LOG2E_Q15;
  assign p_d          = p_full[PW-1:SHIFT-6];
  assign unused_p_low = ^p_full[SHIFT-7:0];

  // ---------------- Stage 2: split y into integer and fraction ----------------
  logic signed [KW+5:0] p_q;
  logic                 valid1_q;
  logic signed [KW-1:0] k;
  logic signed [KW-1:0] neg_k;
  logic [5:0]           j;
  logic [4:0]           s_d;

  // The register keeps only floor(y) and the top fraction bits, so k is the
  // arithmetic right shift of the full product.
  assign k     = p_q[KW+5:6];
  assign j     = p_q[5:0];
  assign neg_k = -k;
  // Any shift of 16 or more already yields 0; saturating keeps s narrow.
  assign s_d   = (neg_k > S_SAT) ? 5'd31 : neg_k[4:0];

  // ---------------- Stage 3: shift and accumulate ----------------
  logic [15:0]          lut_q;
  logic [4:0]           s_q;
  logic                 valid2_q;
  logic [15:0]          exp_d;
  logic [IDX_W-1:0]     cnt_q;
  logic [SUM_WIDTH-1:0] acc_q;
  logic [SUM_WIDTH-1:0] acc_d;

  assign exp_d = (s_q >= 5'd16) ? 16'd0 : (lut_q >> s_q);
  assign acc_d = acc_q + {{(SUM_WIDTH-16){1'b0}}, exp_d};

  logic [15:0]          exp_q;
  logic                 valid_o_q;
  logic [IDX_W-1:0]     index_q;
  logic [SUM_WIDTH-1:0] sum_q;
  logic                 sum_valid_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      p_q         <= '0;
      valid1_q    <= 1'b0;
      lut_q       <= '0;
      s_q         <= '0;
      valid2_q    <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      exp_q       <= '0;
      valid_o_q   <= 1'b0;
      index_q     <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      valid1_q    <= valid_i;
      lut_q       <= lut_rom[j];
      s_q         <= s_d;
      valid2_q    <= valid1_q;
      valid_o_q   <= valid2_q;
      sum_valid_q <= 1'b0;
      if (valid2_q) begin
        exp_q   <= exp_d;
        index_q <= cnt_q;
        if (cnt_q == LAST_IDX) begin
          // Frame complete: publish the sum and restart from 0 so a
          // back-to-back frame needs no bubble.
          cnt_q       <= '0;
          acc_q       <= '0;
          sum_q       <= acc_d;
          sum_valid_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          acc_q <= acc_d;
        end
      end
    end
  end

  assign exp_o       = exp_q;
  assign valid_o     = valid_o_q;
  assign index_o     = index_q;
  assign sum_o       = sum_q;
  assign sum_valid_o = sum_valid_q;

endmodule

// File: tb/tb_exp_accumulate_block.sv
// Directed testbench for exp_accumulate_block (default parameters).
module tb_exp_accumulate_block;

  logic               clock_i = 1'b0;
  logic               reset_i;
  logic               valid_i;
  logic signed [16:0] sub_data_i;
  logic [15:0]        exp_o;
  logic               valid_o;
  logic [3:0]         index_o;
  logic [19:0]        sum_o;
  logic               sum_valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  exp_accumulate_block dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .sub_data_i  (sub_data_i),
    .exp_o       (exp_o),
    .valid_o     (valid_o),
    .index_o     (index_o),
    .sum_o       (sum_o),
    .sum_valid_o (sum_valid_o)
  );

  initial forever #5 clock_i = ~clock_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required end of test");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Inputs change on the falling edge; after the next rising edge we are back
  // on a falling edge where outputs are stable.
  task automatic drive(input logic v, input int x);
    valid_i    = v;
    sub_data_i = 17'(x);
    @(negedge clock_i);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, " valid_o"}, 32'(valid_o), 32'd0);
    chk({tag, " sum_valid_o"}, 32'(sum_valid_o), 32'd0);
  endtask

  task automatic expect_out(input string tag, input int idx, input int ex,
                            input bit last, input int sum);
    $display("%s: index_o=%0d exp_o=%0d sum_valid_o=%0b sum_o=%0d",
             tag, index_o, exp_o, sum_valid_o, sum_o);
    chk({tag, " valid_o"}, 32'(valid_o), 32'd1);
    chk({tag, " index_o"}, 32'(index_o), 32'(idx));
    chk({tag, " exp_o"}, 32'(exp_o), 32'(ex));
    chk({tag, " sum_valid_o"}, 32'(sum_valid_o), 32'(last));
    if (last) chk({tag, " sum_o"}, 32'(sum_o), 32'(sum));
  endtask

  task automatic expect_all_zero(input string tag);
    chk({tag, " valid_o"}, 32'(valid_o), 32'd0);
    chk({tag, " exp_o"}, 32'(exp_o), 32'd0);
    chk({tag, " index_o"}, 32'(index_o), 32'd0);
    chk({tag, " sum_o"}, 32'(sum_o), 32'd0);
    chk({tag, " sum_valid_o"}, 32'(sum_valid_o), 32'd0);
  endtask

  int single_x [6]   = '{0, -256, -128, 300, -4096, -65536};
  int single_exp [6] = '{32768, 11967, 19696, 32768, 0, 0};
  int gap_x [10]     = '{0, -256, -128, 300, -4096, -65536, 0, -256, -128, 0};
  int gap_exp [10]   = '{32768, 11967, 19696, 32768, 0, 0, 32768, 11967, 19696, 32768};

  initial begin
    int gap_sum;
    reset_i    = 1'b1;
    valid_i    = 1'b0;
    sub_data_i = '0;

    // ---- reset held for 3 cycles, then idle ----
    for (int c = 0; c < 3; c++) begin
      @(negedge clock_i);
      expect_all_zero($sformatf("reset%0d", c));
    end
    reset_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 0);
      expect_all_zero($sformatf("idle%0d", c));
    end

    // ---- isolated single values: output exactly 3 cycles after input ----
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, single_x[i]);
      expect_idle($sformatf("single%0d lat1", i));
      drive(1'b0, 0);
      expect_idle($sformatf("single%0d lat2", i));
      drive(1'b0, 0);
      expect_out($sformatf("single%0d x=%0d", i, single_x[i]), i, single_exp[i], 1'b0, 0);
      drive(1'b0, 0);
      expect_idle($sformatf("single%0d after", i));
      chk($sformatf("single%0d exp_o hold", i), 32'(exp_o), 32'(single_exp[i]));
    end

    // Reset to start the frame tests from element 0
    reset_i = 1'b1;
    drive(1'b0, 0);
    reset_i = 1'b0;
    expect_all_zero("reset2");

    // ---- full frame of zeros ----
    for (int d = 0; d < 12; d++) begin
      int e;
      drive(d < 10, 0);
      e = d - 2;
      if (e >= 0 && e < 10)
        expect_out($sformatf("frame e%0d", e), e, 32768, e == 9, 327680);
      else
        expect_idle($sformatf("frame d%0d", d));
    end
    drive(1'b0, 0);
    expect_idle("frame tail");
    chk("frame sum_o hold", 32'(sum_o), 32'd327680);

    // ---- back-to-back frames A (all 0) then B (5x0, 5x-4096) ----
    for (int d = 0; d < 22; d++) begin
      int e;
      drive(d < 20, (d >= 15 && d < 20) ? -4096 : 0);
      e = d - 2;
      if (e >= 0 && e < 20)
        expect_out($sformatf("b2b e%0d", e), e % 10, (e < 15) ? 32768 : 0,
                   (e == 9) || (e == 19), (e == 9) ? 327680 : 163840);
      else
        expect_idle($sformatf("b2b d%0d", d));
    end
    drive(1'b0, 0);
    chk("b2b sum_o hold", 32'(sum_o), 32'd163840);

    // ---- partial frame, reset, then gapped frame ----
    for (int d = 0; d < 6; d++) drive(1'b1, -256);
    reset_i = 1'b1;
    drive(1'b0, 0);
    reset_i = 1'b0;
    expect_all_zero("midreset");

    gap_sum = 0;
    for (int i = 0; i < 10; i++) gap_sum += gap_exp[i];
    for (int d = 0; d < 23; d++) begin
      int src;
      drive((d < 20) && (d % 2 == 0), gap_x[(d < 20) ? d / 2 : 0]);
      src = d - 2;
      if (src >= 0 && src < 20 && (src % 2 == 0))
        expect_out($sformatf("gap e%0d", src / 2), src / 2, gap_exp[src / 2],
                   (src / 2) == 9, gap_sum);
      else
        expect_idle($sformatf("gap d%0d", d));
    end
    chk("gap sum_o hold", 32'(sum_o), 32'(gap_sum));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exp_accumulate_block.md
Name: exp_accumulate_block

Overview:
- Softmax stage directly downstream of the downscale (max-subtract) block.
- Consumes the stream of non-positive signed differences (x − max), computes exp(x) per element in fixed point, and emits each exp value as a stream.
- Accumulates the per-frame sum of exp values (the softmax denominator) for the following divide stage.
- Frame length is a fixed parameter.

Parameters:
- DATA_SIZE, 16: width of the upstream raw data; the input here is DATA_SIZE+1 bits signed.
- NUMBER_OF_DATA, 10: elements per frame.
- FRAC_BITS, 8: fractional bits of the input fixed-point format.
- SUM_WIDTH, 16+$clog2(NUMBER_OF_DATA) (20 at defaults): accumulator width.

Ports:
- clock_i  in  1  sole clock; all logic rising-edge.
- reset_i  in  1  synchronous, active-high reset.
- valid_i  in  1  sub_data_i is valid this cycle; no backpressure, so it may be high every cycle.
- sub_data_i  in  DATA_SIZE+1  signed x − max, with FRAC_BITS fraction bits.
- exp_o  out  16  unsigned Q1.15 exp(x); 1.0 = 32768.
- valid_o  out  1  exp_o valid.
- index_o  out  $clog2(NUMBER_OF_DATA)  element index of exp_o within the frame, 0..N−1.
- sum_o  out  SUM_WIDTH  unsigned Q.15 sum of the frame's exp values.
- sum_valid_o  out  1  one-cycle pulse; sum_o holds the complete frame sum.

Behaviour:
- Reset (reset_i=1 at a clock edge):
  - All outputs go to 0.
  - Pipeline valids, element counter and accumulator are cleared.
  - Reset mid-frame discards the partial frame; the first valid_i after reset is element 0.
- Latency is fixed at 3 cycles from valid_i to valid_o, with throughput 1 element/cycle.
  - Each valid_i yields exactly one valid_o 3 cycles later.
  - Gaps in valid_i propagate as gaps in valid_o.
- Stage 1:
  - Clamp: x>0 is treated as x=0.
  - Register p = x_clamped × 47274, where 47274 is log2(e) in Q1.15. p is a signed product with FRAC_BITS+15 fraction bits.
- Stage 2:
  - Compute y = p / 2^(FRAC_BITS+15).
  - k = floor(y), obtained by arithmetic right shift (k ≤ 0).
  - j = top 6 bits of the fraction field of p.
  - L = LUT[j], where LUT[j] = round(2^(j/64) × 32768), giving 32768..64830 in a 64×16 ROM.
  - Register L and s = −k.
- Stage 3:
  - exp_o = L >> s (logical, floor).
  - If s ≥ 16, exp_o = 0.
  - By construction exp_o ≤ 32768.
- Element counter:
  - Increments on each valid_o.
  - index_o presents the count before increment.
  - Wraps to 0 after index N−1.
- Accumulator:
  - On each valid_o, acc += exp_o.
  - On the valid_o with index_o = N−1, the same cycle drives sum_o = acc_prev + exp_o and sum_valid_o = 1, and the accumulator restarts at 0.
  - A back-to-back next frame therefore accumulates from 0 with no bubble.
  - sum_o holds its value until the next sum_valid_o.
- No overflow is possible: N × 32768 < 2^SUM_WIDTH.
- exp_o and index_o hold their last values when valid_o = 0. Consumers qualify them with valid_o.

Test Plan:
- Reset/idle: hold reset_i=1 for 3 cycles, then release with valid_i=0 → all outputs 0. Check no valid_o and no sum_valid_o.
- Single values, each sent as an isolated valid_i, each valid_o exactly 3 cycles after its valid_i:
  - x=0 → exp_o=32768.
  - x=−256 (−1.0): k=−2, j=35 → exp_o=11967.
  - x=−128 (−0.5): k=−1, j=17 → exp_o=19696.
- Saturation edges:
  - x=+300 → clamped, exp_o=32768.
  - x=−4096 (−16.0): s=24 → exp_o=0.
  - x=−65536 (most negative 17-bit) → exp_o=0 with no wrap.
- Full frame: 10 back-to-back valid_i with x=0 → index_o 0..9 over 10 consecutive cycles. sum_valid_o pulses once with index_o=9, sum_o=327680.
- Back-to-back frames: frame A all x=0, immediately followed by frame B with 5×0 and 5×(−4096) → sum_o=327680 then 163840, exactly 10 cycles apart. The accumulator carries no residue from frame A.
- Reset mid-frame and gapped input: send 6 elements, assert reset_i for 1 cycle, then send 10 elements with valid_i toggling 1/0 → no sum_valid_o from the partial frame. The new frame's indices start at 0; sum_valid_o fires on the 10th valid element; sum_o equals the reference-model sum.
